blink_timer_bank: RTL and testbench

Parametrised bank of independent LED blink timers, the multi-channel successor to the single fixed-period board-clock LED divider. Each channel alternates low and high phases of a runtime-programmable length and can run free or as a one-shot. Configuration uses a simple single-cycle write port driven by the top level or a control FSM. Outputs drive LEDR bits and per-channel tick pulses for other blocks.

---
 rtl/blink_pkg.sv | 22 ++
 rtl/blink_channel.sv | 120 ++++++++++++
 rtl/blink_timer_bank.sv | 47 ++++
 tb/tb_blink_timer_bank.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/blink_pkg.sv
// Shared definitions for the LED blink timer bank: channel state encoding,
// the reset-time phase length, and the channel-index width helper.
package blink_pkg;

  // Per-channel sequencing states; led is high only in HIGH.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOW  = 2'd1,
    HIGH = 2'd2,
    DONE = 2'd3
  } blink_state_e;

  // Phase length loaded at reset: half a second at 150 MHz, matching the
  // board-clock divider this bank replaces.
  localparam int unsigned BLINK_DEFAULT_HALF = 32'd75_000_000;

  // Width of a channel index; a single-channel bank still gets one bit.
  function automatic int ch_width(input int channels);
    return (channels > 1) ? $clog2(channels) : 1;
  endfunction

endpackage

// File: rtl/blink_channel.sv
// One blink timer channel: phase-length and mode registers, a phase counter,
// and the IDLE/LOW/HIGH/DONE sequencer with registered led and tick.
// Optional feature: define BLINK_SYNC_EN to let the sync input realign a
// running channel to the start of its LOW phase.
module blink_channel
  import blink_pkg::*;
#(
  parameter int          CNT_W        = 32,
  parameter int unsigned DEFAULT_HALF = BLINK_DEFAULT_HALF
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             en,
  input  logic             cfg_we,
  input  logic [CNT_W-1:0] cfg_half,
  input  logic             cfg_oneshot,
  input  logic             sync,
  output logic             led,
  output logic             tick
);

  blink_state_e     state;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] half_q;
  logic             oneshot_q;
  logic             phase_end;
  logic             realign;

  // A phase ends once the count reaches the programmed length. Using >=
  // rather than == means a length shrunk below the current count still ends
  // the phase on the next edge instead of waiting for a wrap.
  assign phase_end = (count >= half_q);

`ifdef BLINK_SYNC_EN
  // Only running channels are pulled back to the start of LOW.
  assign realign = sync && ((state == LOW) || (state == HIGH));
`else
  // Port kept for a uniform interface; the signal goes nowhere.
  logic unused_sync;
  assign unused_sync = sync;
  assign realign     = 1'b0;
`endif

  // Configuration registers: a write lands at the edge, so the phase-end
  // decision in the write cycle still sees the previous length and mode.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      half_q    <= CNT_W'(DEFAULT_HALF);
      oneshot_q <= 1'b0;
    end else if (cfg_we) begin
      half_q    <= cfg_half;
      oneshot_q <= cfg_oneshot;
    end
  end

  // Sequencer with registered outputs; priority is en low, then realign,
  // then phase end, then counting.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      count <= '0;
      led   <= 1'b0;
      tick  <= 1'b0;
    end else begin
      // NOTE: every register here uses <= so all of them update from the
      // same pre-edge values; a blocking = would let later lines see the
      // already-updated count or state and skew the phase by a cycle.
      tick <= 1'b0;
      if (!en) begin
        state <= IDLE;
        count <= '0;
        led   <= 1'b0;
      end else if (realign) begin
        state <= LOW;
        count <= '0;
        led   <= 1'b0;
      end else begin
        unique case (state)
          IDLE: begin
            state <= LOW;
            count <= '0;
            led   <= 1'b0;
          end
          LOW: begin
            if (phase_end) begin
              state <= HIGH;
              count <= '0;
              led   <= 1'b1;
              tick  <= 1'b1;
            end else begin
              count <= count + CNT_W'(1);
            end
          end
          HIGH: begin
            if (phase_end) begin
              state <= oneshot_q ? DONE : LOW;
              count <= '0;
              led   <= 1'b0;
              tick  <= 1'b1;
            end else begin
              count <= count + CNT_W'(1);
            end
          end
          DONE: begin
            // Parked until en drops; led stays low.
            state <= DONE;
            count <= '0;
            led   <= 1'b0;
          end
          default: begin
            state <= IDLE;
            count <= '0;
            led   <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: rtl/blink_timer_bank.sv
// Bank of independent LED blink timers sharing one configuration write port.
// Optional feature: define BLINK_SYNC_EN to enable the global sync realign;
// without it the sync port is present but has no effect.
module blink_timer_bank
  import blink_pkg::*;
#(
  parameter int          CHANNELS     = 4,
  parameter int          CNT_W        = 32,
  parameter int unsigned DEFAULT_HALF = BLINK_DEFAULT_HALF
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [CHANNELS-1:0]           en,
  input  logic                          cfg_we,
  input  logic [ch_width(CHANNELS)-1:0] cfg_ch,
  input  logic [CNT_W-1:0]              cfg_half,
  input  logic                          cfg_oneshot,
  input  logic                          sync,
  output logic [CHANNELS-1:0]           led,
  output logic [CHANNELS-1:0]           tick
);

  localparam int CH_W = ch_width(CHANNELS);

  // Each channel matches its own index only, so an index at or beyond
  // CHANNELS selects nothing and the write is dropped.
  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic hit;
    assign hit = cfg_we && (cfg_ch == CH_W'(i));

    blink_channel #(
      .CNT_W        (CNT_W),
      .DEFAULT_HALF (DEFAULT_HALF)
    ) u_channel (
      .clock       (clock),
      .reset       (reset),
      .en          (en[i]),
      .cfg_we      (hit),
      .cfg_half    (cfg_half),
      .cfg_oneshot (cfg_oneshot),
      .sync        (sync),
      .led         (led[i]),
      .tick        (tick[i])
    );
  end

endmodule

// File: tb/tb_blink_timer_bank.sv
// Self-checking bench for blink_timer_bank. Expected outputs are pushed to a
// scoreboard queue as each cycle's stimulus is driven and popped when the
// cycle's outputs are sampled on the falling edge.
module tb_blink_timer_bank;

  logic        clock = 1'b0;
  logic        reset = 1'b1;

  logic [3:0]  en;
  logic        cfg_we;
  logic [1:0]  cfg_ch;
  logic [31:0] cfg_half;
  logic        cfg_oneshot;
  logic        sync;
  logic [3:0]  led;
  logic [3:0]  tick;

  // Three-channel copy: a 2-bit index can address a nonexistent channel 3.
  logic [2:0]  en3;
  logic        cfg_we3;
  logic [1:0]  cfg_ch3;
  logic [31:0] cfg_half3;
  logic        cfg_oneshot3;
  logic        sync3;
  logic [2:0]  led3;
  logic [2:0]  tick3;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    string      tag;
    logic [3:0] led;
    logic [3:0] tick;
    logic [2:0] led3;
    logic [2:0] tick3;
  } exp_t;

  exp_t sb[$];

  always #5 clock = ~clock;

  blink_timer_bank #(.CHANNELS(4), .CNT_W(32), .DEFAULT_HALF(3)) dut (
    .clock       (clock),
    .reset       (reset),
    .en          (en),
    .cfg_we      (cfg_we),
    .cfg_ch      (cfg_ch),
    .cfg_half    (cfg_half),
    .cfg_oneshot (cfg_oneshot),
    .sync        (sync),
    .led         (led),
    .tick        (tick)
  );

  blink_timer_bank #(.CHANNELS(3), .CNT_W(32), .DEFAULT_HALF(3)) dut3 (
    .clock       (clock),
    .reset       (reset),
    .en          (en3),
    .cfg_we      (cfg_we3),
    .cfg_ch      (cfg_ch3),
    .cfg_half    (cfg_half3),
    .cfg_oneshot (cfg_oneshot3),
    .sync        (sync3),
    .led         (led3),
    .tick        (tick3)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  // {led, tick} after edge n for a free-running channel that entered LOW at
  // edge s with phase length h: each phase is h+1 cycles.
  function automatic logic [1:0] free_run(input int n, input int s, input int h);
    int k;
    if (n < s) return 2'b00;
    k = n - s;
    return {((k / (h + 1)) % 2) == 1, (k > 0) && ((k % (h + 1)) == 0)};
  endfunction

  // {led, tick} for a one-shot channel: one LOW phase, one HIGH phase, done.
  function automatic logic [1:0] one_shot(input int n, input int s, input int h);
    int k;
    if (n < s) return 2'b00;
    k = n - s;
    return {(k >= h + 1) && (k < 2 * (h + 1)), (k == h + 1) || (k == 2 * (h + 1))};
  endfunction

  // Inputs for the coming edge are already driven; queue what that edge
  // must produce, let it happen, then compare on the falling edge.
  task automatic advance(input string tag, input logic [3:0] el, input logic [3:0] et,
                         input logic [2:0] el3, input logic [2:0] et3);
    exp_t e;
    sb.push_back('{tag, el, et, el3, et3});
    @(posedge clock);
    @(negedge clock);
    e = sb.pop_front();
    check({e.tag, "_led"},   32'(led),   32'(e.led));
    check({e.tag, "_tick"},  32'(tick),  32'(e.tick));
    check({e.tag, "_led3"},  32'(led3),  32'(e.led3));
    check({e.tag, "_tick3"}, 32'(tick3), 32'(e.tick3));
    cfg_we  = 1'b0;
    cfg_we3 = 1'b0;
    sync    = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset   = 1'b1;
    en      = '0;
    en3     = '0;
    cfg_we  = 1'b0;
    cfg_we3 = 1'b0;
    sync    = 1'b0;
    @(negedge clock);
    check("rst_led",   32'(led),   32'd0);
    check("rst_tick",  32'(tick),  32'd0);
    check("rst_led3",  32'(led3),  32'd0);
    check("rst_tick3", 32'(tick3), 32'd0);
    reset = 1'b0;
  endtask

  task automatic write_cfg(input logic [1:0] ch, input int half, input logic os);
    cfg_we      = 1'b1;
    cfg_ch      = ch;
    cfg_half    = 32'(half);
    cfg_oneshot = os;
  endtask

  initial begin
    logic [1:0] p0, p1, p2, p3;
    int         tg[4];
    int         ticks1;
    int         toggles;

    en = '0; cfg_we = 0; cfg_ch = '0; cfg_half = '0; cfg_oneshot = 0; sync = 0;
    en3 = '0; cfg_we3 = 0; cfg_ch3 = '0; cfg_half3 = '0; cfg_oneshot3 = 0; sync3 = 0;

    // Default length 3 on channel 0; the 3-channel copy runs all channels
    // while writes aimed at index 3 must be dropped.
    do_reset();
    en  = 4'b0001;
    en3 = 3'b111;
    for (int n = 0; n < 18; n++) begin
      if (n < 2) begin
        cfg_we3 = 1'b1; cfg_ch3 = 2'd3; cfg_half3 = 32'd0; cfg_oneshot3 = 1'b1;
      end
      p0 = free_run(n, 0, 3);
      advance("dflt", {3'b000, p0[1]}, {3'b000, p0[0]}, {3{p0[1]}}, {3{p0[0]}});
    end

    // Channel 1 one-shot with length 1, restarted by toggling en; channel 2
    // with length 0 toggles every cycle.
    do_reset();
    ticks1 = 0;
    for (int n = 0; n < 21; n++) begin
      if (n == 0) write_cfg(2'd1, 1, 1'b1);
      if (n == 1) write_cfg(2'd2, 0, 1'b0);
      if (n < 2)       en = 4'b0000;
      else if (n < 12) en = 4'b0110;
      else if (n < 14) en = 4'b0100;
      else             en = 4'b0110;
      if (n < 12)      p1 = one_shot(n, 2, 1);
      else if (n < 14) p1 = 2'b00;
      else             p1 = one_shot(n, 14, 1);
      p2 = free_run(n, 2, 0);
      advance("oneshot", {1'b0, p2[1], p1[1], 1'b0}, {1'b0, p2[0], p1[0], 1'b0}, 3'b000, 3'b000);
      if (n >= 2 && n < 12 && tick[1]) ticks1++;
    end
    check("oneshot_ticks", 32'(ticks1), 32'd2);

    // Length 10 shrunk to 2 at count 7 ends the phase on the next edge; a
    // write in the cycle where count equals length transitions on the old
    // value. Transitions land on edges 10, 13, 16, 22.
    do_reset();
    tg = '{10, 13, 16, 22};
    for (int n = 0; n < 25; n++) begin
      if (n == 0)  write_cfg(2'd0, 10, 1'b0);
      if (n == 9)  write_cfg(2'd0, 2, 1'b0);
      if (n == 16) write_cfg(2'd0, 5, 1'b0);
      en = (n >= 1) ? 4'b0001 : 4'b0000;
      toggles = 0;
      p0 = 2'b00;
      for (int j = 0; j < 4; j++) begin
        if (tg[j] <= n) toggles++;
        if (tg[j] == n) p0[0] = 1'b1;
      end
      p0[1] = (toggles % 2) == 1;
      advance("shrink", {3'b000, p0[1]}, {3'b000, p0[0]}, 3'b000, 3'b000);
    end

    // Reset restores length 3 on channel 0; dropping en mid-HIGH clears led
    // on the next edge with no tick. A write to an index past the bank is
    // not possible here, so only channel 0 runs.
    do_reset();
    for (int n = 0; n < 11; n++) begin
      en = (n < 6) ? 4'b0001 : 4'b0000;
      p0 = (n < 6) ? free_run(n, 0, 3) : 2'b00;
      advance("endrop", {3'b000, p0[1]}, {3'b000, p0[0]}, 3'b000, 3'b000);
    end

    // Channels 0 and 1 start two cycles apart; a sync pulse at edge 5
    // realigns them when the feature is built in and is ignored otherwise.
    do_reset();
    for (int n = 0; n < 19; n++) begin
      en   = (n >= 2) ? 4'b0011 : 4'b0001;
      sync = (n == 5);
`ifdef BLINK_SYNC_EN
      p0 = (n < 5) ? free_run(n, 0, 3) : free_run(n, 5, 3);
      p1 = (n < 5) ? free_run(n, 2, 3) : free_run(n, 5, 3);
`else
      p0 = free_run(n, 0, 3);
      p1 = free_run(n, 2, 3);
`endif
      p3 = 2'b00;
      advance("sync", {2'b00, p1[1], p0[1]}, {2'b00, p1[0], p0[0]}, {3{p3[1]}}, {3{p3[0]}});
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
